// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one G-bit group resolved per stage,
// global stall on output backpressure, registered carry/overflow/zero flags.
module pipelined_cla_adder #(
  parameter int N = 32,
  parameter int G = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);
  localparam int S = N / G;

  logic         stall;
  logic [S-1:0] vld_p;
  logic [S-1:0] vld_src;
  logic [N-1:0] a_p     [S];
  logic [N-1:0] b_p     [S];
  logic [N-1:0] sum_p   [S];
  logic         cy_p    [S];
  logic [N-1:0] a_src   [S];
  logic [N-1:0] b_src   [S];
  logic [N-1:0] sum_src [S];
  logic         cy_src  [S];
  logic [N-1:0] sum_n   [S];
  logic         cy_n    [S];
  logic         ctop_n;
  logic [N-1:0] s_q;
  logic         c_out_q;
  logic         ovf_q;
  logic         zero_q;

  assign out_valid = vld_p[S-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Entry: subtract is folded into an inverted B with the carry forced high;
  // later stages take their inputs from the previous stage registers.
  always_comb begin
    a_src[0]   = a;
    b_src[0]   = sub ? ~b : b;
    sum_src[0] = '0;
    cy_src[0]  = sub | c_in;
    vld_src[0] = in_valid;
    for (int i = 1; i < S; i++) begin
      a_src[i]   = a_p[i-1];
      b_src[i]   = b_p[i-1];
      sum_src[i] = sum_p[i-1];
      cy_src[i]  = cy_p[i-1];
      vld_src[i] = vld_p[i-1];
    end
  end

  // Per-stage group resolve: generate/propagate chain seeded by the incoming group carry.
  always_comb begin
    logic c;
    logic p;
    logic g;
    int   k;
    c      = 1'b0;
    p      = 1'b0;
    g      = 1'b0;
    k      = 0;
    ctop_n = 1'b0;
    for (int i = 0; i < S; i++) begin
      c        = cy_src[i];
      sum_n[i] = sum_src[i];
      for (int j = 0; j < G; j++) begin
        k           = i * G + j;
        p           = a_src[i][k] ^ b_src[i][k];
        g           = a_src[i][k] & b_src[i][k];
        sum_n[i][k] = p ^ c;
        if (k == N - 1) ctop_n = c;
        c = g | (p & c);
      end
      cy_n[i] = c;
    end
  end

  // Stage registers: valid bits are reset, operand/sum skew registers are not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else if (!stall) begin
      for (int i = 0; i < S; i++) vld_p[i] <= vld_src[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int i = 0; i < S; i++) begin
        a_p[i]   <= a_src[i];
        b_p[i]   <= b_src[i];
        sum_p[i] <= sum_n[i];
        cy_p[i]  <= cy_n[i];
      end
    end
  end

  // Output stage: result and flags load together; a bubble loads zeros so the
  // outputs read 0 whenever out_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (!stall) begin
      if (vld_src[S-1]) begin
        s_q     <= sum_n[S-1];
        c_out_q <= cy_n[S-1];
        ovf_q   <= cy_n[S-1] ^ ctop_n;
        zero_q  <= (sum_n[S-1] == '0);
      end else begin
        s_q     <= '0;
        c_out_q <= 1'b0;
        ovf_q   <= 1'b0;
        zero_q  <= 1'b0;
      end
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder at N=8, G=4 (two stages): directed vectors,
// random streaming against an arithmetic reference, backpressure and reset.
module tb_pipelined_cla_adder;
  localparam int N = 8;
  localparam int G = 4;
  localparam int S = N / G;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] s;
  logic         c_out;
  logic         ovf;
  logic         zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.N(N), .G(G)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  // Reference: plain N+1 bit unsigned sum for s/c_out, signed integer range for ovf.
  function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic ci, input logic sb);
    res_t         r;
    logic [N-1:0] y2;
    logic         ci2;
    logic [N:0]   full;
    int           sv;
    y2   = sb ? ~y : y;
    ci2  = sb ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, y2} + {{N{1'b0}}, ci2};
    sv   = int'($signed(x)) + int'($signed(y2)) + (ci2 ? 1 : 0);
    r.s  = full[N-1:0];
    r.c  = full[N];
    r.v  = (sv > (2 ** (N - 1)) - 1) || (sv < -(2 ** (N - 1)));
    r.z  = (full[N-1:0] == '0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for its result, then let the pipe drain a cycle.
  task automatic send_single(input logic [N-1:0] x, input logic [N-1:0] y,
                             input logic ci, input logic sb,
                             output res_t r, output int lat);
    a = x; b = y; c_in = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1;
    r   = '0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        lat = e;
        r   = {s, c_out, ovf, zero};
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (s !== '0) begin n_fail++; $display("FAIL reset_s: got %h want 00", s); end
    n_tests++; if ({c_out, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {c_out, ovf, zero}); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b0;
    tick();
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_add_wrap();
    res_t r; int lat;
    send_single(8'hFF, 8'h01, 1'b0, 1'b0, r, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL add_wrap_latency: got %0d want 2", lat); end
    n_tests++; if (r !== {8'h00, 1'b1, 1'b0, 1'b1}) begin n_fail++; $display("FAIL add_wrap: got s=%h c=%b v=%b z=%b want 00 1 0 1", r.s, r.c, r.v, r.z); end
  endtask

  task automatic test_subtract();
    res_t r; int lat;
    send_single(8'h05, 8'h07, 1'b1, 1'b1, r, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL sub_latency: got %0d want 2", lat); end
    n_tests++; if (r !== {8'hFE, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sub_borrow: got s=%h c=%b v=%b z=%b want fe 0 0 0", r.s, r.c, r.v, r.z); end
    send_single(8'h80, 8'h01, 1'b0, 1'b1, r, lat);
    n_tests++; if (r !== {8'h7F, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL sub_ovf: got s=%h c=%b v=%b z=%b want 7f 1 1 0", r.s, r.c, r.v, r.z); end
  endtask

  task automatic test_add_overflow();
    res_t r; int lat;
    send_single(8'h7F, 8'h01, 1'b0, 1'b0, r, lat);
    n_tests++; if (r !== {8'h80, 1'b0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL add_ovf: got s=%h c=%b v=%b z=%b want 80 0 1 0", r.s, r.c, r.v, r.z); end
    send_single(8'h10, 8'h20, 1'b1, 1'b0, r, lat);
    n_tests++; if (r !== {8'h31, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_cin: got s=%h c=%b v=%b z=%b want 31 0 0 0", r.s, r.c, r.v, r.z); end
  endtask

  task automatic test_back_to_back();
    res_t exp_r [16];
    logic want_v;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16 + S + 2; cyc++) begin
      want_v = (cyc >= S) && (cyc < 16 + S);
      n_tests++; if (out_valid !== want_v) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", cyc, out_valid, want_v); end
      if (want_v) begin
        n_tests++;
        if ({s, c_out, ovf, zero} !== exp_r[cyc-S]) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b", cyc - S,
                   s, c_out, ovf, zero, exp_r[cyc-S].s, exp_r[cyc-S].c, exp_r[cyc-S].v, exp_r[cyc-S].z);
        end
      end
      if (cyc < 16) begin
        a = N'($urandom); b = N'($urandom);
        c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        exp_r[cyc] = model(a, b, c_in, sub);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    res_t         q [$];
    res_t         cur;
    int           sent = 0;
    int           got = 0;
    int           stalls = 0;
    logic         need_new = 1'b1;
    logic [N-1:0] held_s = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", cyc, in_ready); end
        if (stalls > 1) begin
          n_tests++; if (s !== held_s) begin n_fail++; $display("FAIL bp_s_hold[%0d]: got %h want %h", cyc, s, held_s); end
        end
        held_s = s;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_result[%0d]: got s=%h want no result", cyc, s);
        end else begin
          cur = q.pop_front();
          if ({s, c_out, ovf, zero} !== cur) begin
            n_fail++;
            $display("FAIL bp_result[%0d]: got s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b", got,
                     s, c_out, ovf, zero, cur.s, cur.c, cur.v, cur.z);
          end
        end
        got++;
      end
      if (sent < 6) begin
        if (need_new) begin
          a = N'($urandom); b = N'($urandom);
          c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
          need_new = 1'b0;
        end
        in_valid = 1'b1;
        if (in_ready) begin
          q.push_back(model(a, b, c_in, sub));
          sent++;
          need_new = 1'b1;
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_tests++; if (got != 6 || q.size() != 0) begin n_fail++; $display("FAIL bp_delivered: got %0d results (%0d pending) want 6 (0)", got, q.size()); end
    n_tests++; if (stalls != 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 3", stalls); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate[%0d]: got out_valid=%b want 0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stream();
    res_t r; int lat;
    out_ready = 1'b1;
    a = 8'h11; b = 8'h22; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 8'h33; b = 8'h44;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got out_valid=%b want 1", out_valid); end
    reset = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || s !== '0) begin n_fail++; $display("FAIL mid_reset_async: got out_valid=%b s=%h want 0 00", out_valid, s); end
    n_tests++; if ({c_out, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_flags: got %b want 000", {c_out, ovf, zero}); end
    tick();
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_hold: got out_valid=%b want 0", out_valid); end
    reset = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got out_valid=%b want 0", i, out_valid); end
    end
    send_single(8'h03, 8'h04, 1'b0, 1'b0, r, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL mid_new_latency: got %0d want 2", lat); end
    n_tests++; if (r.s !== 8'h07) begin n_fail++; $display("FAIL mid_new_result: got %h want 07", r.s); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_subtract();
    test_add_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Operands are split into G-bit groups. Each pipeline stage resolves one group with a lookahead carry chain and registers the group carry into the next stage.
- Serves as the wide-datapath successor to the team's single-cycle combinational CLA adder: one result per clock at full throughput, with added subtract mode and status flags.

Parameters:
- N, 32, operand/result width in bits; must be a multiple of G.
- G, 8, group width resolved per stage; pipeline depth S = N/G stages, S >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- c_in  input  1  carry in; ignored when sub=1.
- sub  input  1  0: a+b+c_in; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- s  output  N  sum/difference.
- c_out  output  1  carry out of bit N-1; in subtract mode 1 means no borrow.
- ovf  output  1  signed overflow, c[N] ^ c[N-1].
- zero  output  1  s == 0.

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits clear, out_valid=0;
  - s, c_out, ovf and zero are driven to 0 while out_valid=0 (all output registers clear);
  - in_ready=1 immediately after reset.
- Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - When stall=1, every stage register holds, including valid bits.
  - When stall=0, every stage advances one position.
- Accept: a beat is accepted when in_valid & in_ready. The stage-0 valid bit loads in_valid & in_ready on each advancing edge.
- Latency: exactly S cycles from the accepting edge to out_valid=1, measured with no stalls. Throughput is one beat per cycle.
- Stall extension: a stall of k cycles delays every in-flight beat by k cycles. Beats are never dropped, duplicated or reordered.
- Operand preprocessing at entry:
  - b_eff = sub ? ~b : b;
  - c0 = sub ? 1 : c_in.
- Stage i (0..S-1):
  - p = a_grp ^ b_grp and g = a_grp & b_grp for group i (bits iG..iG+G-1);
  - lookahead carries c[j+1] = g[j] | p[j]&c[j], seeded from the registered carry of stage i-1 (c0 for stage 0);
  - sum bits = p ^ c;
  - registers: the group-i sum bits, carry out of the group, and the top-bit carry-in c[N-1] (used in the last stage only).
- Skew handling: each stage forwards the remaining upper operand groups and the already-resolved lower sum groups. Final-stage registers hold the full N-bit s.
- Flags (final stage, registered together with s):
  - c_out = c[N];
  - ovf = c[N] ^ c[N-1];
  - zero = (s == 0).
- Bubbles occupy stage slots. Stalls freeze bubbles too; there is no bubble collapse.
- S=1 (N==G): degenerates to a single registered stage with latency 1; all handshake rules are unchanged.
- Arithmetic is modulo 2^N; c_out and ovf report the wrap.
- Reset mid-operation: all in-flight beats are discarded. No out_valid pulse occurs during or after reset until new beats have traversed the pipe.
- in_valid while in_ready=0: the beat is not accepted. The source must hold a, b, c_in and sub stable until acceptance.

Test Plan:
- N=8,G=4 (S=2): a=8'hFF, b=8'h01, c_in=0, sub=0, one beat, out_ready=1 -> out_valid high exactly 2 cycles later; s=8'h00, c_out=1, ovf=0, zero=1.
- Subtract: a=8'h05, b=8'h07, sub=1, c_in=1 (ignored) -> s=8'hFE, c_out=0, ovf=0, zero=0. Also a=8'h80, b=8'h01, sub=1 -> s=8'h7F, c_out=1, ovf=1.
- Signed overflow add: a=8'h7F, b=8'h01, c_in=0 -> s=8'h80, c_out=0, ovf=1. Also a=8'h10, b=8'h20, c_in=1 -> s=8'h31, flags 0.
- Throughput: 16 back-to-back random beats, out_ready=1 -> 16 consecutive out_valid cycles starting at cycle 2; results match a scoreboard in order.
- Backpressure: stream 6 beats, drop out_ready for 3 cycles mid-stream -> in_ready=0 and s stable during the stall; all 6 results delivered in order, none lost or duplicated.
- Reset mid-stream: assert reset with 2 beats in flight -> out_valid=0 and s=0 within the same cycle. After release, in_ready=1 and no stale result appears. A new beat a=8'h03, b=8'h04 yields s=8'h07 after 2 cycles.
